// File: rtl/sorted_merge_stream.sv
// Merges two ascending 4-word vectors into one ascending 8-beat valid/ready stream.
// A tie goes to A, so the merge is stable; a sticky flag catches unsorted input vectors.
module sorted_merge_stream #(
  parameter int unsigned DW = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW*4-1:0]   in_a,
  input  logic [DW*4-1:0]   in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_src,
  output logic              out_last,
  output logic              order_err
);

  localparam int unsigned LANES = 4;
  localparam int unsigned IW    = $clog2(LANES);
  localparam int unsigned PW    = 3;
  localparam int unsigned SW    = PW + 1;

  typedef enum logic {IDLE, MERGE} state_t;

  state_t          state_q;
  logic [DW-1:0]   ra_q [LANES];
  logic [DW-1:0]   rb_q [LANES];
  logic [PW-1:0]   pa_q;
  logic [PW-1:0]   pb_q;
  logic            order_err_q;

  logic            a_done;
  logic            b_done;
  logic            sel_b;
  logic            last;
  logic            merging;
  logic            beat;
  logic            accept;
  logic            unsorted;
  logic [DW-1:0]   head_a;
  logic [DW-1:0]   head_b;

  // Head selection: exhausted side loses, otherwise the smaller head wins (A on ties).
  always_comb begin
    merging = (state_q == MERGE);
    a_done  = (pa_q == PW'(LANES));
    b_done  = (pb_q == PW'(LANES));
    head_a  = ra_q[pa_q[IW-1:0]];
    head_b  = rb_q[pb_q[IW-1:0]];
    sel_b   = 1'b0;
    if (a_done) begin
      sel_b = 1'b1;
    end else if (b_done) begin
      sel_b = 1'b0;
    end else begin
      sel_b = !(head_a <= head_b);
    end
    last = merging && ((SW'(pa_q) + SW'(pb_q)) == SW'(7));
  end

  // Adjacent-lane order check on the incoming pair.
  always_comb begin
    unsorted = 1'b0;
    for (int unsigned i = 0; i < LANES - 1; i++) begin
      if ((in_a[DW*i +: DW] > in_a[DW*(i+1) +: DW]) ||
          (in_b[DW*i +: DW] > in_b[DW*(i+1) +: DW])) begin
        unsorted = 1'b1;
      end
    end
  end

  // rst_n gates in_ready so the block refuses input while held in reset.
  always_comb begin
    out_valid = merging;
    out_data  = sel_b ? head_b : head_a;
    out_src   = sel_b;
    out_last  = last;
    in_ready  = rst_n && (!merging || (last && out_ready));
    order_err = order_err_q;
    beat      = merging && out_ready;
    accept    = in_valid && in_ready;
  end

  // A new pair on the final beat reloads in place, so pairs run back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pa_q        <= '0;
      pb_q        <= '0;
      order_err_q <= 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
        ra_q[i] <= '0;
        rb_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          ra_q[i] <= in_a[DW*i +: DW];
          rb_q[i] <= in_b[DW*i +: DW];
        end
        pa_q    <= '0;
        pb_q    <= '0;
        state_q <= MERGE;
        if (unsorted) begin
          order_err_q <= 1'b1;
        end
      end else if (beat) begin
        if (sel_b) begin
          pb_q <= pb_q + PW'(1);
        end else begin
          pa_q <= pa_q + PW'(1);
        end
        if (last) begin
          state_q <= IDLE;
        end
      end
    end
  end

endmodule
